intra_dc_seq: RTL and testbench
===============================

Name: intra_dc_seq

Overview:
- Per-macroblock sequencer for the intra DC-value pre-computation datapath (luma 16x16 and 4:2:0 chroma 8x8 DC).
- Clears the accumulators, then walks the reference-accumulation phases, driving the mode, index and pred_start/pred_done controls.
- Then steps the four chroma quadrants and strobes valid so downstream logic samples dc_y/dc_u/dc_v.
- Sits between the intra top-level MB controller and the DC pre-computation datapath.

Parameters:
- RD_HOLD, 1: cycles each chroma quadrant index is held during readout (1..4).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mb_start  in  1  start-of-MB pulse; accepted only when busy=0
- mb_avail_t_i  in  1  top neighbour available; sampled with an accepted mb_start
- mb_avail_l_i  in  1  left neighbour available; sampled with an accepted mb_start
- busy  out  1  high from the cycle after acceptance through the mb_done cycle
- mb_done  out  1  one-cycle pulse when the MB sequence completes
- mb_avail_t  out  1  latched top availability, held for the whole MB
- mb_avail_l  out  1  latched left availability, held for the whole MB
- curr_mode  out  4  datapath phase code
- blk16x16_num  out  4  luma reference index 0..15
- blk_uv_num  out  3  chroma reference index 0..7; quadrant 0..3 during readout
- pred_start  out  1  one-cycle pulse, one cycle before the first accumulate cycle
- pred_done  out  1  one-cycle pulse on the last accumulate cycle
- dc_y_vld  out  1  dc_y valid; first readout cycle only
- dc_uv_vld  out  1  dc_u/dc_v valid for quadrant blk_uv_num[1:0]

Behaviour:
- Reset values: busy=0, mb_done=0, pred_start=0, pred_done=0, dc_y_vld=0, dc_uv_vld=0, curr_mode=4'b1111, blk16x16_num=0, blk_uv_num=0, mb_avail_t=0, mb_avail_l=0.
- All outputs are registered.
- States: IDLE, CLR, Y_V, Y_H, C_V, C_H, RD, DONE.
- curr_mode per state:
  - IDLE and CLR: 1111 (datapath clears its sums).
  - Y_V: 0000 (luma top). Y_H: 0001 (luma left). C_V: 1010 (chroma top). C_H: 1001 (chroma left).
  - RD and DONE: 0010, a hold code so the sums are retained.
- IDLE: mb_start=1 latches availability and goes to CLR. mb_start while busy is ignored; no queuing.
- CLR lasts one cycle. pred_start=1 in CLR if at least one accumulate phase will run.
- Accumulate phases run in the fixed order Y_V, Y_H, C_V, C_H.
  - Y phases: 16 cycles, blk16x16_num counts 0..15.
  - C phases: 8 cycles, blk_uv_num counts 0..7.
  - Counters reset to 0 on phase entry.
- Phase selection without the optional feature: all four phases always run, giving 48 accumulate cycles.
- pred_done=1 on the final cycle of the last phase that runs. Next state is RD.
- RD: blk_uv_num = {1'b0, quad}, quad 0..3, each held RD_HOLD cycles.
  - dc_uv_vld=1 throughout RD.
  - dc_y_vld=1 in the first RD cycle only.
  - blk16x16_num=0 during RD.
- DONE: one cycle, mb_done=1, then IDLE. busy falls in the IDLE cycle.
- Latency with mb_start in cycle T and RD_HOLD=1, full sequence:
  - CLR at T+1.
  - Accumulate T+2..T+49.
  - RD T+50..T+53.
  - mb_done at T+54.
- If no phase runs (feature on, no neighbours): CLR goes directly to RD, no pred_start/pred_done, mb_done at T+6.
- mb_start coinciding with mb_done is ignored; a new MB is accepted from IDLE only.
- rst asserted mid-MB: immediate return to reset values. No mb_done is issued for the aborted MB.

Optional Feature:
- Macro: INTRA_DC_SKIP_UNAVAIL_EN.
- Defined: Y_V and C_V run only if mb_avail_t=1; Y_H and C_H run only if mb_avail_l=1. Skipped phases take zero cycles. pred_start/pred_done attach to the first/last phase that runs.
- Undefined: all phases always run, giving fixed 54-cycle MB timing. Unused sums are ignored by the datapath's availability mux.

Decomposition:
- Shared package: 4-bit mode codes (IDLE 1111, I16_V 0000, I16_H 0001, DC_HOLD 0010, CHROMA_V 1010, CHROMA_H 1001), phase lengths (16, 8) and the state encoding.
- One sub-module is natural: intra_dc_phase_cnt. It is a loadable up-counter with a terminal-count flag, shared by all phases and by readout.

Test Plan:
- Both neighbours available, RD_HOLD=1, mb_start at T:
  - Required: curr_mode 0000 at T+2..T+17, 0001 at T+18..T+33, 1010 at T+34..T+41, 1001 at T+42..T+49.
  - Required: pred_start at T+1, pred_done at T+49, mb_done at T+54.
- Datapath attached, all top luma refs=10, left luma refs=30, both available -> dc_y=20 when dc_y_vld=1.
- Feature on, top only -> only Y_V and C_V run, pred_done at T+25, mb_done at T+30. Feature on, neither neighbour -> mb_done at T+6 with no pred_start.
- RD_HOLD=2 -> blk_uv_num readout sequence 0,0,1,1,2,2,3,3 with dc_uv_vld=1; dc_y_vld=1 in the first RD cycle only.
- mb_start pulsed at T+10 and at T+54 during an active MB -> both ignored; busy stays high; a single mb_done pulse.
- rst asserted at T+20 -> outputs return to reset values asynchronously; the next mb_start runs a full clean sequence.

Source files
------------

// File: rtl/intra_dc_seq_pkg.sv
// Shared definitions for the intra DC pre-computation sequencer: datapath mode codes,
// accumulate phase lengths and the sequencer state encoding.
package intra_dc_seq_pkg;

    localparam int CNT_W = 4;

    localparam logic [3:0] MODE_IDLE     = 4'b1111;
    localparam logic [3:0] MODE_I16_V    = 4'b0000;
    localparam logic [3:0] MODE_I16_H    = 4'b0001;
    localparam logic [3:0] MODE_DC_HOLD  = 4'b0010;
    localparam logic [3:0] MODE_CHROMA_V = 4'b1010;
    localparam logic [3:0] MODE_CHROMA_H = 4'b1001;

    localparam int LEN_Y = 16;
    localparam int LEN_C = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_Y_V,
        ST_Y_H,
        ST_C_V,
        ST_C_H,
        ST_RD,
        ST_DONE
    } state_t;

    function automatic logic [3:0] mode_of(input state_t s);
        logic [3:0] m;
        case (s)
            ST_Y_V:         m = MODE_I16_V;
            ST_Y_H:         m = MODE_I16_H;
            ST_C_V:         m = MODE_CHROMA_V;
            ST_C_H:         m = MODE_CHROMA_H;
            ST_RD, ST_DONE: m = MODE_DC_HOLD;
            default:        m = MODE_IDLE;
        endcase
        return m;
    endfunction

    function automatic logic is_phase(input state_t s);
        return (s inside {ST_Y_V, ST_Y_H, ST_C_V, ST_C_H});
    endfunction

endpackage

// File: rtl/intra_dc_phase_cnt.sv
// Loadable up-counter with terminal-count flag; indexes every accumulate phase and the readout.
module intra_dc_phase_cnt
    import intra_dc_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             tc
);

    assign tc      = (cnt == last);
    assign cnt_nxt = load ? '0 : cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/intra_dc_seq.sv
// Per-macroblock sequencer for the intra DC pre-computation datapath.
// Optional INTRA_DC_SKIP_UNAVAIL_EN: skip accumulate phases whose neighbour is unavailable.
module intra_dc_seq
    import intra_dc_seq_pkg::*;
#(
    parameter int RD_HOLD = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mb_start,
    input  logic       mb_avail_t_i,
    input  logic       mb_avail_l_i,
    output logic       busy,
    output logic       mb_done,
    output logic       mb_avail_t,
    output logic       mb_avail_l,
    output logic [3:0] curr_mode,
    output logic [3:0] blk16x16_num,
    output logic [2:0] blk_uv_num,
    output logic       pred_start,
    output logic       pred_done,
    output logic       dc_y_vld,
    output logic       dc_uv_vld
);

    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(LEN_Y - 1);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(LEN_C - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(4 * RD_HOLD - 1);
    localparam logic [CNT_W-1:0] Q1      = CNT_W'(RD_HOLD);
    localparam logic [CNT_W-1:0] Q2      = CNT_W'(2 * RD_HOLD);
    localparam logic [CNT_W-1:0] Q3      = CNT_W'(3 * RD_HOLD);

    state_t           state_q;
    state_t           state_nxt;
    logic [3:0]       run_mask;
    logic [3:0]       acc_mask;
    logic             accept;
    logic             load;
    logic             tc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] phase_last;
    logic [1:0]       quad_nxt;
    logic             pred_start_nxt;
    logic             pred_done_nxt;
    logic [3:0]       blk16_nxt;
    logic [2:0]       blk_uv_nxt;

    // Mask bits: [0] Y_V, [1] Y_H, [2] C_V, [3] C_H.
`ifdef INTRA_DC_SKIP_UNAVAIL_EN
    assign run_mask = {mb_avail_l, mb_avail_t, mb_avail_l, mb_avail_t};
    assign acc_mask = {mb_avail_l_i, mb_avail_t_i, mb_avail_l_i, mb_avail_t_i};
`else
    assign run_mask = 4'b1111;
    assign acc_mask = 4'b1111;
`endif

    // First enabled phase strictly after s in the fixed order, or readout if none remain.
    function automatic state_t phase_after(input state_t s, input logic [3:0] m);
        state_t r;
        r = ST_RD;
        if (m[3] && (s inside {ST_IDLE, ST_CLR, ST_Y_V, ST_Y_H, ST_C_V})) r = ST_C_H;
        if (m[2] && (s inside {ST_IDLE, ST_CLR, ST_Y_V, ST_Y_H}))         r = ST_C_V;
        if (m[1] && (s inside {ST_IDLE, ST_CLR, ST_Y_V}))                 r = ST_Y_H;
        if (m[0] && (s inside {ST_IDLE, ST_CLR}))                         r = ST_Y_V;
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] last_of(input state_t s);
        logic [CNT_W-1:0] l;
        case (s)
            ST_Y_V, ST_Y_H: l = Y_LAST;
            ST_C_V, ST_C_H: l = C_LAST;
            ST_RD:          l = RD_LAST;
            default:        l = '0;
        endcase
        return l;
    endfunction

    assign accept     = (state_q == ST_IDLE) && mb_start;
    assign phase_last = last_of(state_q);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (mb_start) state_nxt = ST_CLR;
            ST_CLR:  state_nxt = phase_after(ST_CLR, run_mask);
            ST_Y_V, ST_Y_H, ST_C_V, ST_C_H:
                     if (tc) state_nxt = phase_after(state_q, run_mask);
            ST_RD:   if (tc) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The counter restarts on every state change, so each phase and the readout start at index 0.
    assign load = (state_nxt != state_q) || (state_q == ST_IDLE);

    intra_dc_phase_cnt u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .last    (phase_last),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt),
        .tc      (tc)
    );

    always_comb begin
        quad_nxt = 2'd0;
        if (cnt_nxt >= Q3) begin
            quad_nxt = 2'd3;
        end else if (cnt_nxt >= Q2) begin
            quad_nxt = 2'd2;
        end else if (cnt_nxt >= Q1) begin
            quad_nxt = 2'd1;
        end
    end

    always_comb begin
        blk16_nxt  = '0;
        blk_uv_nxt = '0;
        case (state_nxt)
            ST_Y_V, ST_Y_H: blk16_nxt  = cnt_nxt;
            ST_C_V, ST_C_H: blk_uv_nxt = cnt_nxt[2:0];
            ST_RD:          blk_uv_nxt = {1'b0, quad_nxt};
            default:        ;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    assign pred_start_nxt = accept && (phase_after(ST_IDLE, acc_mask) != ST_RD);
    assign pred_done_nxt  = is_phase(state_nxt) && (cnt_nxt == last_of(state_nxt)) &&
                            (phase_after(state_nxt, run_mask) == ST_RD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy         <= 1'b0;
            mb_done      <= 1'b0;
            mb_avail_t   <= 1'b0;
            mb_avail_l   <= 1'b0;
            curr_mode    <= MODE_IDLE;
            blk16x16_num <= '0;
            blk_uv_num   <= '0;
            pred_start   <= 1'b0;
            pred_done    <= 1'b0;
            dc_y_vld     <= 1'b0;
            dc_uv_vld    <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            busy         <= (state_nxt != ST_IDLE);
            mb_done      <= (state_nxt == ST_DONE);
            curr_mode    <= mode_of(state_nxt);
            blk16x16_num <= blk16_nxt;
            blk_uv_num   <= blk_uv_nxt;
            pred_start   <= pred_start_nxt;
            pred_done    <= pred_done_nxt;
            dc_y_vld     <= (state_nxt == ST_RD) && (cnt_nxt == '0);
            dc_uv_vld    <= (state_nxt == ST_RD);
            if (accept) begin
                mb_avail_t <= mb_avail_t_i;
                mb_avail_l <= mb_avail_l_i;
            end
        end
    end

endmodule

// File: tb/tb_intra_dc_seq.sv
// Directed testbench for intra_dc_seq: one instance with RD_HOLD=1 and one with RD_HOLD=2.
module tb_intra_dc_seq;

    localparam int TR_N = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mb_start = 1'b0;
    logic at_i = 1'b0;
    logic al_i = 1'b0;

    logic       busy, mb_done, mb_avail_t, mb_avail_l, pred_start, pred_done, dc_y_vld, dc_uv_vld;
    logic [3:0] curr_mode, blk16x16_num;
    logic [2:0] blk_uv_num;

    logic       busy2, mb_done2, mb_avail_t2, mb_avail_l2, pred_start2, pred_done2, dc_y_vld2, dc_uv_vld2;
    logic [3:0] curr_mode2, blk16x16_num2;
    logic [2:0] blk_uv_num2;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [3:0] tr_mode   [TR_N];
    logic [3:0] tr_blk16  [TR_N];
    logic [2:0] tr_blkuv  [TR_N];
    logic [1:0] tr_avail  [TR_N];
    logic       tr_busy   [TR_N];
    logic       tr_pstart [TR_N];
    logic       tr_pdone  [TR_N];
    logic       tr_done   [TR_N];
    logic       tr_yvld   [TR_N];
    logic       tr_uvvld  [TR_N];
    logic [2:0] tr_blkuv2 [TR_N];
    logic       tr_done2  [TR_N];
    logic       tr_yvld2  [TR_N];
    logic       tr_uvvld2 [TR_N];

    int sum_y = 0;
    int idx_yv = 0;
    int idx_cv = 0;
    int dc_y_q = -1;
    int cap_idx_yv = -1;
    int cap_idx_cv = -1;

    intra_dc_seq #(.RD_HOLD(1)) dut (
        .clk(clk), .rst(rst), .mb_start(mb_start),
        .mb_avail_t_i(at_i), .mb_avail_l_i(al_i),
        .busy(busy), .mb_done(mb_done), .mb_avail_t(mb_avail_t), .mb_avail_l(mb_avail_l),
        .curr_mode(curr_mode), .blk16x16_num(blk16x16_num), .blk_uv_num(blk_uv_num),
        .pred_start(pred_start), .pred_done(pred_done), .dc_y_vld(dc_y_vld), .dc_uv_vld(dc_uv_vld)
    );

    intra_dc_seq #(.RD_HOLD(2)) dut2 (
        .clk(clk), .rst(rst), .mb_start(mb_start),
        .mb_avail_t_i(at_i), .mb_avail_l_i(al_i),
        .busy(busy2), .mb_done(mb_done2), .mb_avail_t(mb_avail_t2), .mb_avail_l(mb_avail_l2),
        .curr_mode(curr_mode2), .blk16x16_num(blk16x16_num2), .blk_uv_num(blk_uv_num2),
        .pred_start(pred_start2), .pred_done(pred_done2), .dc_y_vld(dc_y_vld2), .dc_uv_vld(dc_uv_vld2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < TR_N) begin
            tr_mode[cyc]   <= curr_mode;
            tr_blk16[cyc]  <= blk16x16_num;
            tr_blkuv[cyc]  <= blk_uv_num;
            tr_avail[cyc]  <= {mb_avail_t, mb_avail_l};
            tr_busy[cyc]   <= busy;
            tr_pstart[cyc] <= pred_start;
            tr_pdone[cyc]  <= pred_done;
            tr_done[cyc]   <= mb_done;
            tr_yvld[cyc]   <= dc_y_vld;
            tr_uvvld[cyc]  <= dc_uv_vld;
            tr_blkuv2[cyc] <= blk_uv_num2;
            tr_done2[cyc]  <= mb_done2;
            tr_yvld2[cyc]  <= dc_y_vld2;
            tr_uvvld2[cyc] <= dc_uv_vld2;
        end
    end

    // Reference DC datapath: top luma refs are 10, left luma refs are 30.
    always @(negedge clk) begin
        if (curr_mode == 4'b1111) begin
            sum_y  <= 0;
            idx_yv <= 0;
            idx_cv <= 0;
        end else if (curr_mode == 4'b0000) begin
            sum_y  <= sum_y + 10;
            idx_yv <= idx_yv + int'(blk16x16_num);
        end else if (curr_mode == 4'b0001) begin
            sum_y  <= sum_y + 30;
        end else if (curr_mode == 4'b1010) begin
            idx_cv <= idx_cv + int'(blk_uv_num);
        end
        if (dc_y_vld) begin
            dc_y_q     <= (sum_y + 16) / 32;
            cap_idx_yv <= idx_yv;
            cap_idx_cv <= idx_cv;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses mb_start for one cycle with the given neighbours; returns the start cycle.
    task automatic applyStimulus(input logic t, input logic l, output int t0);
        @(negedge clk);
        t0 = cyc;
        mb_start = 1'b1;
        at_i = t;
        al_i = l;
        @(negedge clk);
        mb_start = 1'b0;
        at_i = 1'b0;
        al_i = 1'b0;
    endtask

    function automatic logic [3:0] expMode(input int k);
        if (k >= 2 && k <= 17)  return 4'b0000;
        if (k >= 18 && k <= 33) return 4'b0001;
        if (k >= 34 && k <= 41) return 4'b1010;
        if (k >= 42 && k <= 49) return 4'b1001;
        if (k >= 50 && k <= 54) return 4'b0010;
        return 4'b1111;
    endfunction

    function automatic logic [3:0] expBlk16(input int k);
        if (k >= 2 && k <= 17)  return 4'(k - 2);
        if (k >= 18 && k <= 33) return 4'(k - 18);
        return 4'd0;
    endfunction

    function automatic logic [2:0] expBlkUv(input int k);
        if (k >= 34 && k <= 41) return 3'(k - 34);
        if (k >= 42 && k <= 49) return 3'(k - 42);
        if (k >= 50 && k <= 53) return 3'(k - 50);
        return 3'd0;
    endfunction

    function automatic logic [2:0] expBlkUv2(input int k);
        if (k >= 42 && k <= 49) return 3'(k - 42);
        if (k >= 50 && k <= 57) return 3'((k - 50) / 2);
        return 3'd0;
    endfunction

    // Full sequence with both neighbours, checked cycle by cycle against the fixed MB timeline.
    task automatic checkFullTimeline(input int t0);
        int done_cnt;
        done_cnt = 0;
        for (int k = 0; k <= 56; k++) begin
            checkOutput($sformatf("mode@T+%0d", k), 32'(tr_mode[t0+k]), 32'(expMode(k)));
            checkOutput($sformatf("busy@T+%0d", k), 32'(tr_busy[t0+k]), 32'(k >= 1 && k <= 54));
            checkOutput($sformatf("pred_start@T+%0d", k), 32'(tr_pstart[t0+k]), 32'(k == 1));
            checkOutput($sformatf("pred_done@T+%0d", k), 32'(tr_pdone[t0+k]), 32'(k == 49));
            checkOutput($sformatf("mb_done@T+%0d", k), 32'(tr_done[t0+k]), 32'(k == 54));
            checkOutput($sformatf("blk16@T+%0d", k), 32'(tr_blk16[t0+k]), 32'(expBlk16(k)));
            checkOutput($sformatf("blk_uv@T+%0d", k), 32'(tr_blkuv[t0+k]), 32'(expBlkUv(k)));
            checkOutput($sformatf("dc_uv_vld@T+%0d", k), 32'(tr_uvvld[t0+k]), 32'(k >= 50 && k <= 53));
            checkOutput($sformatf("dc_y_vld@T+%0d", k), 32'(tr_yvld[t0+k]), 32'(k == 50));
        end
        for (int k = 48; k <= 59; k++) begin
            checkOutput($sformatf("h2_blk_uv@T+%0d", k), 32'(tr_blkuv2[t0+k]), 32'(expBlkUv2(k)));
            checkOutput($sformatf("h2_uv_vld@T+%0d", k), 32'(tr_uvvld2[t0+k]), 32'(k >= 50 && k <= 57));
            checkOutput($sformatf("h2_y_vld@T+%0d", k), 32'(tr_yvld2[t0+k]), 32'(k == 50));
            checkOutput($sformatf("h2_mb_done@T+%0d", k), 32'(tr_done2[t0+k]), 32'(k == 58));
        end
        checkOutput("avail@T+1", 32'(tr_avail[t0+1]), 32'h3);
        checkOutput("avail@T+40", 32'(tr_avail[t0+40]), 32'h3);
        for (int k = 0; k <= 62; k++) done_cnt += int'(tr_done[t0+k]);
        checkOutput("mb_done_count", 32'(done_cnt), 32'd1);
        checkOutput("dc_y", 32'(dc_y_q), 32'd20);
        checkOutput("idx_sum_y_v", 32'(cap_idx_yv), 32'd120);
        checkOutput("idx_sum_c_v", 32'(cap_idx_cv), 32'd28);
    endtask

    function automatic int firstOff(input int sel, input int t0);
        logic v;
        for (int k = 0; k <= 61; k++) begin
            case (sel)
                0:       v = tr_pstart[t0+k];
                1:       v = tr_pdone[t0+k];
                default: v = tr_done[t0+k];
            endcase
            if (v === 1'b1) return k;
        end
        return -1;
    endfunction

    task automatic runScenario(input string name, input logic t, input logic l,
                               input int e_ps, input int e_pd, input int e_done, input logic [3:0] e_m18);
        int t0;
        int d;
        applyStimulus(t, l, t0);
        repeat (62) @(negedge clk);
        d = firstOff(2, t0);
        checkOutput({name, "_pred_start_off"}, 32'(firstOff(0, t0)), 32'(e_ps));
        checkOutput({name, "_pred_done_off"}, 32'(firstOff(1, t0)), 32'(e_pd));
        checkOutput({name, "_mb_done_off"}, 32'(d), 32'(e_done));
        checkOutput({name, "_mode@T+18"}, 32'(tr_mode[t0+18]), 32'(e_m18));
        if (d >= 0) begin
            checkOutput({name, "_busy_after_done"}, 32'(tr_busy[t0+d+1]), 32'd0);
        end
    endtask

    initial begin
        int t0;
        int stray;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mb_done", 32'(mb_done), 32'd0);
        checkOutput("rst_curr_mode", 32'(curr_mode), 32'hf);
        checkOutput("rst_blk16", 32'(blk16x16_num), 32'd0);
        checkOutput("rst_blk_uv", 32'(blk_uv_num), 32'd0);
        checkOutput("rst_pred", 32'({pred_start, pred_done}), 32'd0);
        checkOutput("rst_vld", 32'({dc_y_vld, dc_uv_vld}), 32'd0);
        checkOutput("rst_avail", 32'({mb_avail_t, mb_avail_l}), 32'd0);
        checkOutput("rst_h2_mode", 32'(curr_mode2), 32'hf);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full MB with ignored mb_start pulses at T+10 and T+54.
        $display("[TB] full sequence, both neighbours");
        applyStimulus(1'b1, 1'b1, t0);
        repeat (9) @(negedge clk);
        mb_start = 1'b1;
        @(negedge clk);
        mb_start = 1'b0;
        checkOutput("busy_after_ignored_start", 32'(busy), 32'd1);
        repeat (43) @(negedge clk);
        mb_start = 1'b1;
        @(negedge clk);
        mb_start = 1'b0;
        repeat (8) @(negedge clk);
        checkFullTimeline(t0);

        // Reduced neighbour availability.
        $display("[TB] partial availability");
`ifdef INTRA_DC_SKIP_UNAVAIL_EN
        runScenario("top_only", 1'b1, 1'b0, 1, 25, 30, 4'b1010);
        runScenario("none", 1'b0, 1'b0, -1, -1, 6, 4'b1111);
`else
        runScenario("top_only", 1'b1, 1'b0, 1, 49, 54, 4'b0001);
        runScenario("none", 1'b0, 1'b0, 1, 49, 54, 4'b0001);
`endif

        // Asynchronous reset mid-MB, then a clean full sequence.
        $display("[TB] reset mid-MB");
        applyStimulus(1'b1, 1'b1, t0);
        repeat (19) @(negedge clk);
        checkOutput("pre_rst_mode", 32'(curr_mode), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_mode", 32'(curr_mode), 32'hf);
        checkOutput("async_rst_blk16", 32'(blk16x16_num), 32'd0);
        checkOutput("async_rst_avail", 32'({mb_avail_t, mb_avail_l}), 32'd0);
        checkOutput("async_rst_h2_busy", 32'(busy2), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        stray = 0;
        for (int k = 20; k <= 80; k++) stray += int'(tr_done[t0+k]) + int'(tr_done2[t0+k]);
        checkOutput("no_done_after_abort", 32'(stray), 32'd0);
        applyStimulus(1'b1, 1'b1, t0);
        repeat (62) @(negedge clk);
        checkFullTimeline(t0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
